// File: rtl/basic_ram.sv
// basic_ram: word-addressed single-port synchronous RAM with a fixed-latency
// access handshake (capture -> LATENCY cycles -> one-cycle mem_done pulse).
// Optional feature macro: BASIC_RAM_BOUNDS_CHECK_EN
//   defined   : addresses >= DEPTH complete normally, but writes are dropped
//               and reads return zero.
//   undefined : the index is address modulo DEPTH; upper address bits are ignored.
module basic_ram #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  output logic [31:0] data_output,
  input  logic [31:0] data_input,
  output logic        mem_done,
  input  logic        cs,
  input  logic        we,
  input  logic        oe
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic          r_we;
  logic          r_oob;
  logic [31:0]   r_dout;
  logic          r_done;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_oob;
  logic          w_complete;
  logic          w_mem_wr;
  logic [AW-1:0] w_idx;

  assign w_req = cs & (we | oe);
  assign w_idx = address[AW-1:0];

`ifdef BASIC_RAM_BOUNDS_CHECK_EN
  assign w_oob = |address[31:AW];
`else
  logic w_unused_hi;
  assign w_oob       = 1'b0;
  assign w_unused_hi = ^address[31:AW];
`endif

  // The access completes on the edge where BUSY sees the counter at zero.
  assign w_complete = (r_state == BUSY) && (r_cnt == '0);
  assign w_mem_wr   = w_complete && r_we && !r_oob;

  assign data_output = r_dout;
  assign mem_done    = r_done;

  // Handshake FSM: capture request, count down latency, pulse done, return to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_oob   <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_req) begin
            r_addr  <= w_idx;
            r_data  <= data_input;
            r_we    <= we;
            r_oob   <= w_oob;
            r_cnt   <= CNT_LOAD;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            if (!r_we) begin
              r_dout <= r_oob ? '0 : r_mem[r_addr];
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Array write port; contents are never reset. An asynchronous reset forces
  // IDLE, which deasserts w_mem_wr, so an aborted access cannot write.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_addr] <= r_data;
    end
  end

endmodule

// File: tb/tb_basic_ram.sv
// Scoreboarded bench for basic_ram: the stimulus pushes the expected data_output
// for every access it issues, and a monitor pops and compares on each mem_done.
module tb_basic_ram;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LAT    = 2;
  localparam int unsigned HOLD   = 10;
  localparam int unsigned NPULSE = (HOLD + LAT + 1) / (LAT + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_input = '0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic        oe = 1'b0;
  logic [31:0] data_output;
  logic        mem_done;

  int          tests = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_dout = '0;

  basic_ram #(
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .data_output(data_output),
    .data_input (data_input),
    .mem_done   (mem_done),
    .cs         (cs),
    .we         (we),
    .oe         (oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every mem_done pulse must match a pending expected value.
  always @(negedge clk) begin
    if (mem_done) begin
      if (sb_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL spurious_done: mem_done=1 with no pending access expected");
      end else begin
        check("sb_data_output", data_output, sb_q.pop_front());
      end
    end
  end

  // Single access: drive at a negedge, wait for done, release, settle to IDLE.
  task automatic access(input logic w, input logic o, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    int n;
    bit seen;
    if (w) begin
      sb_q.push_back(exp_dout);
    end else begin
      exp_dout = exp_rd;
      sb_q.push_back(exp_rd);
    end
    address    = a;
    data_input = d;
    we         = w;
    oe         = o;
    cs         = 1'b1;
    n          = 0;
    seen       = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_done) seen = 1;
    end
    check("latency", n, LAT + 1);
    cs = 1'b0;
    we = 1'b0;
    oe = 1'b0;
    @(negedge clk);
  endtask

  // Write held for HOLD cycles: repeats every LAT+2 cycles.
  task automatic hold_write(input logic [31:0] a, input logic [31:0] d);
    int first;
    int second;
    int pulses;
    for (int i = 0; i < int'(NPULSE); i++) sb_q.push_back(exp_dout);
    first      = 0;
    second     = 0;
    pulses     = 0;
    address    = a;
    data_input = d;
    we         = 1'b1;
    oe         = 1'b0;
    cs         = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_done) begin
        pulses++;
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (k == int'(HOLD)) begin
        cs = 1'b0;
        we = 1'b0;
      end
    end
    check("hold_first_done", first, LAT + 1);
    check("hold_done_spacing", second - first, LAT + 2);
    check("hold_pulse_count", pulses, NPULSE);
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    check("reset_mem_done", {31'd0, mem_done}, 32'd0);
    check("reset_data_output", data_output, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sequential load, then read back in order.
    hold_write(32'd0, 32'hE3A00001);
    hold_write(32'd1, 32'hE2800002);
    hold_write(32'd2, 32'hEAFFFFFE);
    access(1'b0, 1'b1, 32'd0, 32'd0, 32'hE3A00001);
    access(1'b0, 1'b1, 32'd1, 32'd0, 32'hE2800002);
    access(1'b0, 1'b1, 32'd2, 32'd0, 32'hEAFFFFFE);

    // Reset mid-BUSY aborts a write to address 5.
    access(1'b1, 1'b0, 32'd5, 32'h00005555, 32'd0);
    address    = 32'd5;
    data_input = 32'hDEADBEEF;
    we         = 1'b1;
    cs         = 1'b1;
    @(negedge clk);
    check("busy_no_done", {31'd0, mem_done}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_data_output", data_output, 32'd0);
    check("rst_async_mem_done", {31'd0, mem_done}, 32'd0);
    cs       = 1'b0;
    we       = 1'b0;
    exp_dout = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b1, 32'd5, 32'd0, 32'h00005555);

    // cs low with we high: nothing happens.
    access(1'b1, 1'b0, 32'd9, 32'h99990009, 32'd0);
    address    = 32'd9;
    data_input = 32'hBAD00009;
    we         = 1'b1;
    cs         = 1'b0;
    cnt        = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_done) cnt++;
    end
    we = 1'b0;
    check("cs_low_no_done", cnt, 32'd0);
    check("cs_low_dout_held", data_output, 32'h00005555);
    access(1'b0, 1'b1, 32'd9, 32'd0, 32'h99990009);

    // we and oe together: write wins, data_output unchanged.
    access(1'b1, 1'b1, 32'd3, 32'h12345678, 32'd0);
    check("we_oe_dout_held", data_output, 32'h99990009);
    access(1'b0, 1'b1, 32'd3, 32'd0, 32'h12345678);

    // Out-of-range address DEPTH+1.
`ifdef BASIC_RAM_BOUNDS_CHECK_EN
    access(1'b0, 1'b1, DEPTH + 1, 32'd0, 32'h00000000);
    access(1'b1, 1'b0, DEPTH + 1, 32'hCAFE0017, 32'd0);
    access(1'b0, 1'b1, 32'd1, 32'd0, 32'hE2800002);
    access(1'b0, 1'b1, DEPTH + 1, 32'd0, 32'h00000000);
`else
    access(1'b0, 1'b1, DEPTH + 1, 32'd0, 32'hE2800002);
    access(1'b1, 1'b0, DEPTH + 1, 32'hCAFE0017, 32'd0);
    access(1'b0, 1'b1, 32'd1, 32'd0, 32'hCAFE0017);
    access(1'b0, 1'b1, DEPTH + 1, 32'd0, 32'hCAFE0017);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
